// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor.
// One decimal digit is resolved per clock, least significant digit first, with
// the decimal carry held in a flop between digits. Subtraction is A + (nines'
// complement of B) + 1, so the final carry is the inverted borrow. Any operand
// digit above 9 flags err and forces a zero result, at unchanged latency.
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       res_q;
    logic               sub_q;
    logic               carry_q;
    logic               err_cap_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               err_q;
    logic [W-1:0]       sum_q;

    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [3:0]         bd_dig;
    logic [4:0]         step;
    logic [W-1:0]       res_d;
    logic               last;

    // True when any 4-bit digit of the packed word is above 9.
    function automatic logic any_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Nines' complement for subtraction; invalid digits pass through untouched
    // since the result is discarded anyway.
    function automatic logic [3:0] nines_if(input logic [3:0] d, input logic en);
        if (en && (d <= 4'd9)) begin
            return 4'd9 - d;
        end
        return d;
    endfunction

    // One decimal digit step: returns {carry_out, digit}. raw peaks at 31 only
    // for invalid digits, so 5 bits always suffice.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] ad,
                                                 input logic [3:0] bd,
                                                 input logic       cin);
        logic [4:0] raw;
        raw = {1'b0, ad} + {1'b0, bd} + {4'b0000, cin};
        if (raw > 5'd9) begin
            return {1'b1, raw[3:0] + 4'd6};
        end
        return {1'b0, raw[3:0]};
    endfunction

    // Select the current digit pair, compute it, and merge it into the result.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        res_d = res_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        bd_dig = nines_if(b_dig, sub_q);
        step   = bcd_digit_add(a_dig, bd_dig, carry_q);
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                res_d[4*i +: 4] = step[3:0];
            end
        end
        last = (idx_q == IDX_W'(DIGITS - 1));
    end

    // Control FSM with operand capture, digit loop and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            err_cap_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            sum_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        sub_q     <= sub;
                        carry_q   <= sub;
                        idx_q     <= '0;
                        err_cap_q <= any_invalid(a) | any_invalid(b);
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    res_q   <= res_d;
                    carry_q <= step[4];
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= err_cap_q;
                        sum_q   <= err_cap_q ? '0 : res_d;
                        cout_q  <= ~err_cap_q & (step[4] ^ sub_q);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule
